// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size encodings,
// the controller state enum and the default data memory size.
package lsu_pkg;

    localparam int unsigned LSU_DMEM_BYTES = 128;

    // req_size encodings; 2'b11 is reserved and always faults.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        LD_WAIT  = 2'b01,
        ST_MERGE = 2'b10
    } state_e;

endpackage

// File: rtl/lsu_if.sv
// Pipeline-side request/response bundle of the load/store unit.
//   master : EX/MEM stage, drives req_* and observes stall/rdata/fault.
//   slave  : load_store_unit.
interface lsu_if;

    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        fault;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  stall, rdata, rdata_valid, fault
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output stall, rdata, rdata_valid, fault
    );

endinterface

// File: rtl/lsu_lane_mux.sv
// Combinational lane logic for a big-endian word memory.
//   word     : word read from memory
//   offset   : byte offset within the word
//   size     : access size (byte/half; word passes through)
//   is_unsigned : zero-extend instead of sign-extend on loads
//   wdata    : right-aligned store data (low byte/half used)
//   ld_data  : extracted and extended load value
//   st_data  : word with the store lane merged in
module lsu_lane_mux
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [15:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);

    logic [4:0]  shift;
    logic [31:0] shifted;
    logic [31:0] mask;

    // Offset 0 is the most significant lane, so the shift is (3-k)*8 for
    // bytes and 16 for half offset 0.
    always_comb begin
        shift   = (size == SZ_HALF) ? {~offset[1], 4'b0000} : {~offset, 3'b000};
        shifted = word >> shift;
        mask    = ((size == SZ_HALF) ? 32'h0000_FFFF : 32'h0000_00FF) << shift;
        case (size)
            SZ_BYTE: ld_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            SZ_HALF: ld_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default: ld_data = word;
        endcase
        st_data = (word & ~mask) | ((32'(wdata) << shift) & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store front end between EX/MEM and a word-wide big-endian data memory.
// Aligned word stores complete in IDLE; loads wait one cycle for registered
// read data; byte/half stores do read-modify-write through ST_MERGE.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   bus         : lsu_if.slave request/response bundle
//   mem_addr    : word-aligned memory address (combinational)
//   mem_wdata   : write word (combinational)
//   mem_read    : read intent (combinational)
//   mem_write   : write strobe, sampled by memory at negedge (combinational)
//   mem_rdata   : registered memory read data
// Build option: LSU_RANGE_CHECK_EN faults any req_addr >= DMEM_BYTES.
module load_store_unit
    import lsu_pkg::*;
`ifdef LSU_RANGE_CHECK_EN
#(
    parameter int unsigned DMEM_BYTES = LSU_DMEM_BYTES
)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    lsu_if.slave        bus,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    state_e      state, state_nx;
    logic [29:0] addr_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [15:0] wdata_q;

    logic        range_bad;
    logic        bad_req;
    logic        latch_req;
    logic        fault_nx;
    logic        ld_done;
    logic [31:0] ld_data;
    logic [31:0] merge_data;

    lsu_lane_mux u_lane_mux (
        .word        (mem_rdata),
        .offset      (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .ld_data     (ld_data),
        .st_data     (merge_data)
    );

`ifdef LSU_RANGE_CHECK_EN
    assign range_bad = (bus.req_addr >= 32'(DMEM_BYTES));
`else
    assign range_bad = 1'b0;
`endif

    // Misalignment, reserved size or out-of-range request.
    assign bad_req = (bus.req_size == SZ_RSVD)
                  || ((bus.req_size == SZ_HALF) && bus.req_addr[0])
                  || ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00))
                  || range_bad;

    // Next state and combinational memory/stall outputs.
    always_comb begin
        state_nx  = state;
        bus.stall = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = 32'h0;
        mem_addr  = {addr_q, 2'b00};
        latch_req = 1'b0;
        fault_nx  = 1'b0;
        ld_done   = 1'b0;
        case (state)
            IDLE: begin
                mem_addr = {bus.req_addr[31:2], 2'b00};
                if (bus.req_valid) begin
                    if (bad_req) begin
                        fault_nx = 1'b1;
                    end else if (bus.req_write && (bus.req_size == SZ_WORD)) begin
                        mem_write = 1'b1;
                        mem_wdata = bus.req_wdata;
                    end else begin
                        mem_read  = 1'b1;
                        bus.stall = 1'b1;
                        latch_req = 1'b1;
                        state_nx  = bus.req_write ? ST_MERGE : LD_WAIT;
                    end
                end
            end
            LD_WAIT: begin
                ld_done  = 1'b1;
                state_nx = IDLE;
            end
            ST_MERGE: begin
                mem_write = 1'b1;
                mem_wdata = merge_data;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, request latch and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            addr_q          <= 30'h0;
            off_q           <= 2'b00;
            size_q          <= 2'b00;
            uns_q           <= 1'b0;
            wdata_q         <= 16'h0;
            bus.rdata       <= 32'h0;
            bus.rdata_valid <= 1'b0;
            bus.fault       <= 1'b0;
        end else begin
            state <= state_nx;
            if (latch_req) begin
                addr_q  <= bus.req_addr[31:2];
                off_q   <= bus.req_addr[1:0];
                size_q  <= bus.req_size;
                uns_q   <= bus.req_unsigned;
                wdata_q <= bus.req_wdata[15:0];
            end
            if (ld_done) begin
                bus.rdata <= ld_data;
            end
            bus.rdata_valid <= ld_done;
            bus.fault       <= fault_nx;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural
// big-endian word memory (write at negedge, registered read at posedge).
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic [31:0] mem [0:31];

    int tests_run;
    int tests_failed;

    lsu_if bus ();

    load_store_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (mem_write) mem[mem_addr[6:2]] <= mem_wdata;
    always @(posedge clk) mem_rdata <= mem[mem_addr[6:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] d);
        bus.req_valid    = v;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    // Load: stall in cycle 0, result and valid pulse in cycle 2.
    task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] exp);
        drive(1'b1, 1'b0, sz, uns, a, 32'h0);
        #2;
        check({tag, "_stall0"}, 32'(bus.stall), 32'd1);
        check({tag, "_read0"}, 32'(mem_read), 32'd1);
        tick();
        idle();
        #2;
        check({tag, "_stall1"}, 32'(bus.stall), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(bus.rdata_valid), 32'd1);
        check({tag, "_rdata"}, bus.rdata, exp);
        tick();
        check({tag, "_valid_drop"}, 32'(bus.rdata_valid), 32'd0);
    endtask

    // Sub-word store: write strobe with merged word in cycle 1.
    task automatic do_sub_store(input string tag, input logic [1:0] sz,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] exp);
        drive(1'b1, 1'b1, sz, 1'b0, a, d);
        #2;
        check({tag, "_stall0"}, 32'(bus.stall), 32'd1);
        check({tag, "_write0"}, 32'(mem_write), 32'd0);
        tick();
        idle();
        #2;
        check({tag, "_write1"}, 32'(mem_write), 32'd1);
        check({tag, "_wdata1"}, mem_wdata, exp);
        check({tag, "_addr1"}, mem_addr, {a[31:2], 2'b00});
        check({tag, "_stall1"}, 32'(bus.stall), 32'd0);
        tick();
        check({tag, "_mem"}, mem[a[6:2]], exp);
    endtask

    // Faulting request: no access now, fault pulse next cycle, rdata kept.
    task automatic do_fault(input string tag, input logic w, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] keep);
        drive(1'b1, w, sz, 1'b0, a, 32'h1234_5678);
        #2;
        check({tag, "_stall"}, 32'(bus.stall), 32'd0);
        check({tag, "_write"}, 32'(mem_write), 32'd0);
        check({tag, "_read"}, 32'(mem_read), 32'd0);
        tick();
        idle();
        check({tag, "_fault"}, 32'(bus.fault), 32'd1);
        check({tag, "_novalid"}, 32'(bus.rdata_valid), 32'd0);
        check({tag, "_rdata_kept"}, bus.rdata, keep);
        tick();
        check({tag, "_fault_drop"}, 32'(bus.fault), 32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_read", 32'(mem_read), 32'd0);
        check("rst_write", 32'(mem_write), 32'd0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_valid", 32'(bus.rdata_valid), 32'd0);
        check("rst_fault", 32'(bus.fault), 32'd0);
        rst_n = 1'b1;
        tick();

        // Aligned word store completes in IDLE with no stall.
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h08, 32'hAABB_CCDD);
        #2;
        check("sw_write", 32'(mem_write), 32'd1);
        check("sw_addr", mem_addr, 32'h08);
        check("sw_wdata", mem_wdata, 32'hAABB_CCDD);
        check("sw_stall", 32'(bus.stall), 32'd0);
        tick();
        idle();
        check("sw_mem", mem[2], 32'hAABB_CCDD);
        tick();

        // Loads with sign and zero extension.
        mem[4] = 32'h1180_3344;
        do_load("lb", 2'b00, 1'b0, 32'h11, 32'hFFFF_FF80);
        do_load("lbu", 2'b00, 1'b1, 32'h11, 32'h0000_0080);
        do_load("lw", 2'b10, 1'b0, 32'h10, 32'h1180_3344);

        // Read-modify-write sub-word stores.
        mem[4] = 32'h1122_3344;
        do_sub_store("sb", 2'b00, 32'h13, 32'hFFFF_FF5A, 32'h1122_335A);
        do_sub_store("sh", 2'b01, 32'h10, 32'h1234_BEEF, 32'hBEEF_335A);
        do_load("lh_hi", 2'b01, 1'b0, 32'h10, 32'hFFFF_BEEF);
        do_load("lhu_hi", 2'b01, 1'b1, 32'h10, 32'h0000_BEEF);
        do_load("lh_lo", 2'b01, 1'b0, 32'h12, 32'h0000_335A);

        // Faults keep the last load result (0x0000335A).
        do_fault("lh_mis", 1'b0, 2'b01, 32'h11, 32'h0000_335A);
        do_fault("sw_mis", 1'b1, 2'b10, 32'h0A, 32'h0000_335A);
        do_fault("sz_bad", 1'b0, 2'b11, 32'h10, 32'h0000_335A);

        // Reset during ST_MERGE before the negedge abandons the store.
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h12, 32'h77);
        tick();
        idle();
        check("rstm_write_before", 32'(mem_write), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstm_write", 32'(mem_write), 32'd0);
        check("rstm_stall", 32'(bus.stall), 32'd0);
        check("rstm_read", 32'(mem_read), 32'd0);
        check("rstm_rdata", bus.rdata, 32'h0);
        check("rstm_valid", 32'(bus.rdata_valid), 32'd0);
        check("rstm_fault", 32'(bus.fault), 32'd0);
        tick();
        check("rstm_mem", mem[4], 32'hBEEF_335A);
        rst_n = 1'b1;
        tick();

        // Address at the top of the memory range.
`ifdef LSU_RANGE_CHECK_EN
        do_fault("sw_range", 1'b1, 2'b10, 32'h80, 32'h0);
`else
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h80, 32'hCAFE_F00D);
        #2;
        check("sw_range_write", 32'(mem_write), 32'd1);
        check("sw_range_addr", mem_addr, 32'h80);
        tick();
        idle();
        check("sw_range_fault", 32'(bus.fault), 32'd0);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
